// File: rtl/param_counter_pkg.sv
// rtl/param_counter_pkg.sv - shared types and defaults for param_counter
package param_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/param_counter_prescaler.sv
// rtl/param_counter_prescaler.sv - enabled-cycle prescaler, built only with COUNTER_PRESCALER_EN
`ifdef COUNTER_PRESCALER_EN
module param_counter_prescaler #(
  parameter int PRESCALE = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic step_ok
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Clear wins over counting; the window restarts after the last enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Step is permitted only on the enabled cycle that closes the window.
  always_comb begin
    step_ok = enable && (cnt == LAST);
  end

endmodule
`endif

// File: rtl/param_counter.sv
// rtl/param_counter.sv - parametrised up/down wrap/saturate counter; optional prescaler via COUNTER_PRESCALER_EN
module param_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
`ifdef COUNTER_PRESCALER_EN
  , parameter int PRESCALE = 4
`endif
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  if (WIDTH < 2) begin : g_bad_width
    $error("param_counter: WIDTH must be at least 2");
  end
  if (RST_VAL > MAX_VAL || RST_VAL < 0) begin : g_bad_rst_val
    $error("param_counter: RST_VAL must lie in 0..MAX_VAL");
  end

  cnt_dir_e         dir;
  cnt_mode_e        mode;
  logic             step_ok;
  logic             step;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             ovf_next;

`ifdef COUNTER_PRESCALER_EN
  param_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clear   (load),
    .step_ok (step_ok)
  );
`else
  assign step_ok = 1'b1;
`endif

  // Decode controls and detect whether a step would cross the range boundary.
  always_comb begin
    dir          = cnt_dir_e'(up);
    mode         = cnt_mode_e'(sat_mode);
    step         = enable && !load && step_ok;
    at_bound     = (dir == DIR_UP) ? (count == MAX_C) : (count == '0);
    load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
  end

  // Next state: load beats step beats hold; a boundary step pulses tc and sets ovf.
  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    ovf_next   = ovf && !clr_ovf;
    if (load) begin
      count_next = load_clamped;
    end else if (step) begin
      if (at_bound) begin
        tc_next  = 1'b1;
        ovf_next = 1'b1;
        if (mode == MODE_WRAP) begin
          count_next = (dir == DIR_UP) ? '0 : MAX_C;
        end
      end else begin
        count_next = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
      end
    end
  end

  // Output registers; reset aborts any in-flight update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_C;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= tc_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: doc/param_counter.md
# param_counter

Parametrised, asynchronously reset event counter: the next generation of the team's fixed 4-bit enable counter. It adds configurable width and modulus, up/down direction, a synchronous parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It sits beside the existing counter in the test modules and is driven by the same style of clocked enable stimulus.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- MAX_VAL, 2**WIDTH-1, highest count value; the count range is 0..MAX_VAL
- RST_VAL, 0, count value after reset; must be ≤ MAX_VAL (elaboration error otherwise)
- PRESCALE, 4, enabled cycles per count step; used only when COUNTER_PRESCALER_EN is defined (≥2)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  count-step request, sampled each rising edge
- up  in  1  1 = count up, 0 = count down
- sat_mode  in  1  0 = wrap at the boundary, 1 = saturate at the boundary
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- clr_ovf  in  1  clears the sticky overflow flag
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- ovf  out  1  sticky boundary-event flag (registered)

## Operation
- rst low, at any time and asynchronously: count=RST_VAL, tc=0, ovf=0, prescaler=0. Reset asserted mid-count aborts the operation with no partial update.
- Per-edge priority: load > enable step > hold.
- load=1: count is set to min(load_val, MAX_VAL), so load_val > MAX_VAL clamps. tc=0 that cycle. The prescaler is cleared. ovf is not changed by the load itself.
- A step occurs when enable=1, load=0 and the prescaler permits it (always permits if the macro is absent).
- Up step: if count<MAX_VAL, count+1. At MAX_VAL the count goes to 0 if sat_mode=0, or holds MAX_VAL if sat_mode=1.
- Down step: if count>0, count−1. At 0 the count goes to MAX_VAL if sat_mode=0, or holds 0 if sat_mode=1.
- Boundary step means a step taken while count is at the boundary for its direction (MAX_VAL up, 0 down). A boundary step sets tc=1 for exactly that next cycle in both modes and sets ovf=1.
- tc is 0 on every other cycle. Consecutive boundary steps in saturate mode give tc high on each of those cycles.
- clr_ovf=1 clears ovf. If a clear and a boundary step occur in the same cycle, set wins and ovf=1.
- enable=0 holds count and prescaler; tc returns to 0.
- up and sat_mode may change on any cycle and take effect on the next step.
- Arithmetic is WIDTH bits. MAX_VAL < 2**WIDTH−1 gives a non-power-of-two modulus; no intermediate value may exceed MAX_VAL.

## Timing
- Latency: one cycle from a sampled enable or load to the new count.
- tc is registered and aligned with the updated count: it is high in the same cycle count first shows the wrapped or held value.
- ovf rises in the same cycle as tc and falls one cycle after clr_ovf is sampled.
- No combinational path from any input to any output.

## Configuration
- COUNTER_PRESCALER_EN defined: a prescaler of width $clog2(PRESCALE) counts cycles where enable=1 and load=0.
  - A step occurs only on the enabled cycle where prescaler==PRESCALE−1, and the prescaler then returns to 0.
  - enable=0 freezes the prescaler. load and reset clear it.
- COUNTER_PRESCALER_EN undefined: every qualifying enabled cycle is a step. The PRESCALE parameter and prescaler logic are absent.

## Structure
- Shared package param_counter_pkg holds:
  - typedef cnt_dir_e (DIR_DOWN=0, DIR_UP=1)
  - typedef cnt_mode_e (MODE_WRAP=0, MODE_SAT=1)
  - localparam default WIDTH
- One sub-module, param_counter_prescaler, exists only under COUNTER_PRESCALER_EN. It has clk, rst, enable and clear inputs and a step_ok output.
- Next-count and boundary detection are combinational in the top module; count, tc and ovf are single registers.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, RST_VAL=0, a 10 ns clock and no macro unless stated.
- Reset: hold rst=0 for 10 ns, release, then enable=1 for 5 cycles → count 0,1,2,3,4,5; tc=0; ovf=0. Assert rst=0 mid-count → count=0 immediately, without waiting for a clock edge.
- Up wrap: from 0, up=1, enable for 10 cycles → count reaches 9 then 0; tc high only in the cycle count=0; ovf=1. Pulse clr_ovf → ovf=0 next cycle. clr_ovf together with another wrap → ovf stays 1.
- Down wrap: up=0 at count=0, one step → count=9, tc=1, ovf=1. Next step → count=8, tc=0.
- Saturate: sat_mode=1 at count=9, up=1, enable 3 cycles → count stays 9, tc high on all 3 cycles. Set up=0 → 8, 7.
- Load: load_val=12 → count=9 (clamped). load=1 with enable=1 and load_val=3 → count=3 with no step. Toggle enable 0/1 → count holds while enable is low.
- Prescaler (COUNTER_PRESCALER_EN, PRESCALE=4): enable for 8 cycles → count 0→2, stepping on the 4th and 8th enabled cycles. A load at enabled cycle 2 restarts the 4-cycle window.
